// File: rtl/apb_crc_mem_slave.sv
// +-----------------------------------------------------------------------+
// | apb_crc_mem_slave: APB4 byte memory with lane-XOR CRC on the top lane |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module apb_crc_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [2:0]            PPROT,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  input  logic                  stall_i,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic [7:0]            err_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TOP   = STRB_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [7:0]              mem_q [DEPTH];
  logic [7:0]              mem_d [DEPTH];

  logic                    accept;
  logic [ADDR_WIDTH-1:0]   setup_addr;
  logic                    setup_err;
  logic [DATA_WIDTH-1:0]   rd_lanes;
  logic [DATA_WIDTH-1:0]   rd_data;

  function automatic logic [7:0] crc8(input logic [DATA_WIDTH-1:0] data,
                                      input logic [STRB_WIDTH-1:0] strb);
    logic [7:0] c;
    c = 8'h00;
    for (int j = 0; j < TOP; j++) begin
      if (strb[j]) c = c ^ data[8*j +: 8];
    end
    return c;
  endfunction

  // Every error source depends only on setup-phase fields, so it is resolved once at capture.
  assign setup_addr = PADDR & ~ADDR_WIDTH'(STRB_WIDTH - 1);
  assign setup_err  = (PPROT != setup_addr[ADDR_WIDTH-1 -: 3])
                    || (PWRITE && (PWDATA[DATA_WIDTH-1 -: 8] != crc8(PWDATA, PSTRB)))
                    || (!PWRITE && (PSTRB != '0))
                    || (PWRITE && !PSTRB[TOP]);

  assign accept = PSEL && !PENABLE && ((state_q == IDLE) || (state_q == RESP));

  always_comb begin
    rd_lanes = '0;
    for (int j = 0; j < TOP; j++) begin
      rd_lanes[8*j +: 8] = mem_q[addr_q + ADDR_WIDTH'(j)];
    end
    rd_data = rd_lanes;
    rd_data[DATA_WIDTH-1 -: 8] = crc8(rd_lanes, '1);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_cnt_d = err_cnt_q;
    mem_d     = mem_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!stall_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (err_q) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (write_q) begin
          for (int j = 0; j < STRB_WIDTH; j++) begin
            if (strb_q[j]) mem_d[addr_q + ADDR_WIDTH'(j)] = wdata_q[8*j +: 8];
          end
        end
        state_d = accept ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      cnt_d   = 4'(WAIT_CYCLES);
      addr_d  = setup_addr;
      write_d = PWRITE;
      err_d   = setup_err;
      wdata_d = PWDATA;
      strb_d  = PSTRB;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_cnt_q <= 8'h00;
      mem_q     <= '{default: 8'h00};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      err_q     <= err_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_cnt_q <= err_cnt_d;
      mem_q     <= mem_d;
    end
  end

  assign PREADY  = (state_q == RESP);
  assign PSLVERR = (state_q == RESP) && err_q;
  assign PRDATA  = ((state_q == RESP) && !write_q && !err_q) ? rd_data : '0;
  assign err_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_crc_mem_slave.sv
// +-----------------------------------------------------------------------+
// | tb_apb_crc_mem_slave: scoreboard bench, WAIT_CYCLES=0 and =2 instances |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_apb_crc_mem_slave;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSEL, PENABLE, PWRITE, stall_i, cur;
  logic [9:0]  PADDR;
  logic [2:0]  PPROT;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;

  logic        psel0, psel2;
  logic        ready0, ready2, serr0, serr2;
  logic [31:0] rdata0, rdata2;
  logic [7:0]  ecnt0, ecnt2;
  logic        ready, slverr;
  logic [31:0] prdata;
  logic [7:0]  ecnt;

  always #5 PCLK = ~PCLK;

  assign psel0  = PSEL & ~cur;
  assign psel2  = PSEL & cur;
  assign ready  = cur ? ready2 : ready0;
  assign slverr = cur ? serr2  : serr0;
  assign prdata = cur ? rdata2 : rdata0;
  assign ecnt   = cur ? ecnt2  : ecnt0;

  apb_crc_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PPROT(PPROT), .PWDATA(PWDATA), .PSTRB(PSTRB), .stall_i(stall_i),
    .PREADY(ready0), .PSLVERR(serr0), .PRDATA(rdata0), .err_cnt(ecnt0)
  );

  apb_crc_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PPROT(PPROT), .PWDATA(PWDATA), .PSTRB(PSTRB), .stall_i(stall_i),
    .PREADY(ready2), .PSLVERR(serr2), .PRDATA(rdata2), .err_cnt(ecnt2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mmem [2][1024];
  int          merr [2];

  function automatic logic [7:0] crc(input logic [31:0] d, input logic [3:0] s);
    logic [7:0] c;
    c = 8'h00;
    for (int j = 0; j < 3; j++) if (s[j]) c = c ^ d[8*j +: 8];
    return c;
  endfunction

  function automatic logic [31:0] mkw(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
    return {l0 ^ l1 ^ l2, l2, l1, l0};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      merr[d] = 0;
      for (int i = 0; i < 1024; i++) mmem[d][i] = 8'h00;
    end
  endtask

  // Called just after a negedge; returns at the negedge where PREADY is seen, bus still in access.
  task automatic xfer(input logic wr, input logic [9:0] addr, input logic [2:0] prot,
                      input logic [31:0] wdata, input logic [3:0] strb, input int nstall);
    exp_t       e;
    int         dv;
    int         a;
    int         k;
    logic       seen;
    dv = cur ? 1 : 0;
    a  = int'({addr[9:2], 2'b00});
    e.err = (prot != addr[9:7]) || (wr && (wdata[31:24] != crc(wdata, strb)))
          || (!wr && (strb != 4'h0)) || (wr && !strb[3]);
    e.rdata = 32'h0;
    if (!e.err && !wr) begin
      e.rdata[7:0]   = mmem[dv][a];
      e.rdata[15:8]  = mmem[dv][a+1];
      e.rdata[23:16] = mmem[dv][a+2];
      e.rdata[31:24] = mmem[dv][a] ^ mmem[dv][a+1] ^ mmem[dv][a+2];
    end
    if (!e.err && wr) begin
      for (int j = 0; j < 4; j++) if (strb[j]) mmem[dv][a+j] = wdata[8*j +: 8];
    end
    e.lat = (cur ? 2 : 0) + 1;
    if (nstall + 1 > e.lat) e.lat = nstall + 1;
    sb.push_back(e);

    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PPROT = prot;
    PWDATA = wdata; PSTRB = strb;
    @(negedge PCLK);
    check_eq("ready_after_setup", {31'd0, ready}, 32'd0);
    check_eq("err_cnt", {24'd0, ecnt}, merr[dv]);
    PENABLE = 1'b1;
    PWRITE = ~wr; PADDR = 10'($urandom); PPROT = 3'($urandom);
    PWDATA = $urandom; PSTRB = 4'($urandom);
    stall_i = (nstall >= 1);
    seen = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge PCLK);
      if (ready) begin
        seen = 1'b1;
        break;
      end
      stall_i = (nstall >= k + 1);
    end
    stall_i = 1'b0;
    check_eq("ready_timeout", {31'd0, seen}, 32'd1);
    e = sb.pop_front();
    if (seen) begin
      check_eq("latency", k, e.lat);
      check_eq("pslverr", {31'd0, slverr}, {31'd0, e.err});
      check_eq("prdata", prdata, e.rdata);
      if (e.err && merr[dv] < 255) merr[dv]++;
    end
  endtask

  task automatic idle();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check_eq("ready_one_cycle", {31'd0, ready}, 32'd0);
    check_eq("pslverr_idle", {31'd0, slverr}, 32'd0);
    check_eq("prdata_idle", prdata, 32'd0);
    check_eq("err_cnt_idle", {24'd0, ecnt}, merr[cur ? 1 : 0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    logic [3:0]  st;
    logic [9:0]  ad;
    logic [2:0]  pr;
    logic        wr;
    logic        seen;

    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; stall_i = 1'b0;
    cur = 1'b0; PADDR = '0; PPROT = '0; PWDATA = '0; PSTRB = '0;
    model_reset();
    #12;
    check_eq("rst_ready0", {31'd0, ready0}, 32'd0);
    check_eq("rst_serr0", {31'd0, serr0}, 32'd0);
    check_eq("rst_rdata0", rdata0, 32'd0);
    check_eq("rst_ecnt0", {24'd0, ecnt0}, 32'd0);
    check_eq("rst_ready2", {31'd0, ready2}, 32'd0);
    check_eq("rst_ecnt2", {24'd0, ecnt2}, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Basic write/read and each error kind on the zero-wait instance
    xfer(1'b1, 10'h000, 3'd0, 32'h30123456, 4'hF, 0); idle();
    xfer(1'b0, 10'h000, 3'd0, 32'h0, 4'h0, 0);        idle();
    xfer(1'b1, 10'h000, 3'd3, mkw(8'h11, 8'h22, 8'h33), 4'hF, 0); idle();
    xfer(1'b0, 10'h000, 3'd0, 32'h0, 4'h0, 0);        idle();
    xfer(1'b1, 10'h010, 3'd0, 32'h31123456, 4'hF, 0); idle();
    xfer(1'b0, 10'h010, 3'd0, 32'h0, 4'h1, 0);        idle();
    xfer(1'b1, 10'h010, 3'd0, mkw(8'h01, 8'h02, 8'h03), 4'h7, 0); idle();
    xfer(1'b1, 10'h004, 3'd0, mkw(8'h11, 8'h22, 8'h33), 4'hF, 0); idle();
    xfer(1'b1, 10'h004, 3'd0, 32'hAA1122AA, 4'b1001, 0); idle();
    xfer(1'b0, 10'h006, 3'd0, 32'h0, 4'h0, 0);        idle();
    xfer(1'b1, 10'h3FC, 3'd7, mkw(8'hC3, 8'h5A, 8'h0F), 4'hF, 0); idle();
    xfer(1'b0, 10'h3FD, 3'd7, 32'h0, 4'h0, 0);        idle();
    xfer(1'b1, 10'h020, 3'd0, mkw(8'h9E, 8'h47, 8'hD1), 4'hF, 0);
    xfer(1'b0, 10'h020, 3'd0, 32'h0, 4'h0, 0);
    idle();

    for (int n = 0; n < 24; n++) begin
      ad = 10'($urandom);
      pr = ($urandom % 4 == 0) ? 3'($urandom) : ad[9:7];
      wr = 1'($urandom);
      if (wr) begin
        st = 4'($urandom) | (($urandom % 5 != 0) ? 4'h8 : 4'h0);
        wd = {8'h00, 24'($urandom)};
        wd[31:24] = crc(wd, st);
        if ($urandom % 6 == 0) wd[31:24] = wd[31:24] ^ 8'h5A;
      end else begin
        st = ($urandom % 5 == 0) ? 4'($urandom) : 4'h0;
        wd = $urandom;
      end
      xfer(wr, ad, pr, wd, st, 0);
      if ($urandom % 3 != 0) idle();
    end
    idle();

    // Wait states and stall on the two-wait instance
    cur = 1'b1;
    xfer(1'b1, 10'h040, 3'd0, mkw(8'h12, 8'h34, 8'h56), 4'hF, 0); idle();
    xfer(1'b0, 10'h040, 3'd0, 32'h0, 4'h0, 2); idle();
    xfer(1'b0, 10'h040, 3'd0, 32'h0, 4'h0, 5); idle();

    // Master abandons the transfer mid-WAIT
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h040; PPROT = 3'd0;
    PWDATA = mkw(8'hEE, 8'hDD, 8'hCC); PSTRB = 4'hF;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      seen = seen | ready;
    end
    check_eq("abort_no_ready", {31'd0, seen}, 32'd0);
    check_eq("abort_err_cnt", {24'd0, ecnt}, merr[1]);
    xfer(1'b0, 10'h040, 3'd0, 32'h0, 4'h0, 0); idle();

    // Reset pulsed mid-WAIT
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h044; PPROT = 3'd0;
    PWDATA = mkw(8'h01, 8'h80, 8'h7F); PSTRB = 4'hF;
    @(negedge PCLK); PENABLE = 1'b1;
    @(negedge PCLK); PRESETn = 1'b0;
    #1;
    check_eq("rst_mid_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_mid_ecnt0", {24'd0, ecnt0}, 32'd0);
    model_reset();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    xfer(1'b0, 10'h044, 3'd0, 32'h0, 4'h0, 0); idle();
    xfer(1'b0, 10'h040, 3'd0, 32'h0, 4'h0, 0); idle();

    // err_cnt saturation on the zero-wait instance
    cur = 1'b0;
    repeat (300) begin
      xfer(1'b1, 10'h000, 3'd1, mkw(8'h10, 8'h20, 8'h40), 4'hF, 0);
      idle();
    end
    check_eq("err_cnt_saturated", {24'd0, ecnt0}, 32'h000000FF);
    xfer(1'b0, 10'h000, 3'd0, 32'h0, 4'h0, 0); idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
